ntt_addr_seq: RTL and testbench
===============================

Name: ntt_addr_seq

Overview:
- Loop-sequencer that sits directly upstream of the 4-BFU address generator in the shuffle-top polynomial-multiply datapath.
- On a start pulse it walks every stage of a 1024-point NTT or INTT and emits one address tuple per cycle: stage exponent p, group index k, intra-group index i, flat counter cnt_addr_gen, and the ntt_flag/rev controls.
- The address generator turns each tuple into 8 coefficient addresses.
- Handles downstream stall, inter-stage pipeline drain gaps, and a done handshake.

Parameters:
N_LOG2, 10, log2 of transform length; stage count = N_LOG2, p in 0..N_LOG2-1.
BFU_NUM, 4, butterflies per cycle; 2*BFU_NUM coefficients per tuple.
STAGE_GAP, 6, bubble cycles between stages (BFU/memory drain); 0 allowed.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
start  input  1  begin a pass; honoured only when busy=0.
intt_mode  input  1  1=INTT, 0=NTT; latched at accepted start.
bitrev_en  input  1  request bit-reversed addressing on first stage; latched at start.
stall  input  1  downstream not ready; current tuple held.
k  output  9  group index.
i  output  9  butterfly index within group, in units of BFU_NUM.
p  output  4  stage exponent, J = 1<<p.
cnt_addr_gen  output  7  flat tuple counter within stage, 0..127.
ntt_flag  output  1  latched intt_mode, constant for the pass.
rev  output  1  bit-reverse select for current tuple.
addr_vld  output  1  tuple on k/i/p/cnt_addr_gen/rev is valid.
stage_last  output  1  current tuple is the last of its stage (cnt_addr_gen=127).
busy  output  1  pass in progress.
done  output  1  one-cycle pulse at end of pass.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; every output is 0.
- rst at any time, including mid-pass, returns to IDLE with all outputs 0 on the next edge. No done is generated.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 latches intt_mode and bitrev_en and sets busy=1.
  - The next cycle enters RUN with the first tuple and addr_vld=1. Latency from start to first tuple is 1 cycle.
  - start while busy=1 is ignored.
- Stage order:
  - NTT: p = N_LOG2-1 down to 0.
  - INTT: p = 0 up to N_LOG2-1.
- Tuples per stage: 2^N_LOG2 / (2*BFU_NUM) = 128.
- Tuple acceptance: a tuple is accepted on a cycle with addr_vld=1 and stall=0.
  - With stall=1, all tuple outputs and addr_vld hold.
- Advance on each accepted tuple:
  - cnt_addr_gen increments.
  - If p >= 2: i increments; when i = (J/BFU_NUM)-1, i wraps to 0 and k increments.
  - If p < 2: i stays 0 and k increments every tuple, so k = cnt_addr_gen.
- End of stage (tuple with cnt_addr_gen=127 accepted):
  - Last stage: enter DONE.
  - STAGE_GAP > 0: enter GAP with addr_vld=0 for exactly STAGE_GAP cycles, then RUN with the next p and cnt_addr_gen=k=i=0.
  - STAGE_GAP = 0: next stage's first tuple appears on the following cycle.
- GAP counter runs regardless of stall.
- stage_last = 1 exactly when addr_vld=1 and cnt_addr_gen=127.
- rev = latched bitrev_en on all tuples of the first issued stage; 0 otherwise.
- DONE: lasts one cycle with done=1, busy=0, addr_vld=0, then IDLE. A start in the DONE cycle is ignored.
- Stall-free pass length: N_LOG2*128 + (N_LOG2-1)*STAGE_GAP tuple-plus-gap cycles.

Test Plan:
1. NTT, bitrev_en=0, STAGE_GAP=6, no stall, start at cycle 0:
   - cycle 1: p=9, k=0, i=0, cnt=0.
   - cycle 2: i=1, k=0.
   - cycle 128: cnt=127, stage_last=1.
   - cycles 129-134: addr_vld=0.
   - cycle 135: p=8, cnt=0.
   - Last tuple at cycle 1334 (p=0, k=127); done=1 at cycle 1335.
2. INTT:
   - p=0 first, with k=cnt, i=0.
   - In stage p=3, tuple cnt=5 gives k=2, i=1.
   - In stage p=9, cnt=127 gives k=0, i=127.
   - Final stage p=9.
3. Stall:
   - stall=1 for 3 cycles while cnt=40 is presented: all outputs are frozen, addr_vld=1.
   - Next tuple is cnt=41.
   - done is delayed by exactly 3 cycles versus scenario 1.
4. bitrev_en=1 on NTT: rev=1 on the 128 p=9 tuples; rev=0 for all later tuples.
5. STAGE_GAP=0: cnt goes 127→0 on consecutive cycles with addr_vld continuously 1; done at cycle 1281.
6. Control corner cases:
   - start pulsed mid-pass is ignored.
   - rst asserted during stage p=5: all outputs 0 next cycle, no done.
   - A subsequent start runs a full clean pass.

Source files
------------

// File: rtl/ntt_addr_seq.sv
// rtl/ntt_addr_seq.sv - stage/group/butterfly loop sequencer for the 1024-point NTT/INTT address generator
//
// Walks every stage of an NTT (p high to low) or INTT (p low to high) and
// issues one address tuple per accepted cycle for the downstream 4-BFU
// address generator. An optional bubble of STAGE_GAP cycles separates stages.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a pass (ignored while busy or in the done cycle)
//   intt_mode       1=INTT, 0=NTT, latched at accepted start
//   bitrev_en       bit-reversed addressing on first stage, latched at start
//   stall           downstream not ready, current tuple held
//   k, i, p         group index, intra-group index (BFU units), stage exponent
//   cnt_addr_gen    flat tuple counter within the stage
//   ntt_flag, rev   latched mode, bit-reverse select for current tuple
//   addr_vld        tuple valid
//   stage_last      tuple is the last of its stage
//   busy, done      pass in progress, one-cycle end-of-pass pulse
module ntt_addr_seq #(
  parameter int N_LOG2    = 10,
  parameter int BFU_NUM   = 4,
  parameter int STAGE_GAP = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    intt_mode,
  input  logic                                    bitrev_en,
  input  logic                                    stall,
  output logic [N_LOG2-2:0]                       k,
  output logic [N_LOG2-2:0]                       i,
  output logic [$clog2(N_LOG2)-1:0]               p,
  output logic [N_LOG2-$clog2(2*BFU_NUM)-1:0]     cnt_addr_gen,
  output logic                                    ntt_flag,
  output logic                                    rev,
  output logic                                    addr_vld,
  output logic                                    stage_last,
  output logic                                    busy,
  output logic                                    done
);

  localparam int KW = N_LOG2 - 1;
  localparam int PW = $clog2(N_LOG2);
  localparam int CW = N_LOG2 - $clog2(2 * BFU_NUM);
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [CW-1:0] CNT_LAST   = '1;
  localparam logic [PW-1:0] STAGE_LAST = PW'(N_LOG2 - 1);
  localparam logic [GW-1:0] GAP_LAST   = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   stage_idx, stage_idx_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;

  logic [KW-1:0]   k_n, i_n;
  logic [PW-1:0]   p_n;
  logic [CW-1:0]   cnt_n;
  logic            flag_n, rev_n, vld_n, last_n, busy_n, done_n;

  logic            accept, stage_end, pass_end, gap_end;
  logic [KW-1:0]   i_max;

  assign accept    = (state == RUN) && !stall;
  assign stage_end = accept && (cnt_addr_gen == CNT_LAST);
  assign pass_end  = stage_end && (stage_idx == STAGE_LAST);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);

  // Groups of J = 2^p butterflies span J/BFU_NUM tuples; only meaningful for p >= 2.
  assign i_max = (KW'(1) << (p - PW'(2))) - KW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (pass_end)                        state_n = DONE;
        else if (stage_end && STAGE_GAP > 0) state_n = GAP;
      end
      GAP:  if (gap_end) state_n = RUN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    k_n         = k;
    i_n         = i;
    p_n         = p;
    cnt_n       = cnt_addr_gen;
    flag_n      = ntt_flag;
    rev_n       = rev;
    vld_n       = addr_vld;
    last_n      = stage_last;
    busy_n      = busy;
    done_n      = 1'b0;
    stage_idx_n = stage_idx;
    gap_cnt_n   = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          flag_n      = intt_mode;
          rev_n       = bitrev_en;
          busy_n      = 1'b1;
          vld_n       = 1'b1;
          last_n      = 1'b0;
          p_n         = intt_mode ? '0 : STAGE_LAST;
          k_n         = '0;
          i_n         = '0;
          cnt_n       = '0;
          stage_idx_n = '0;
        end
      end
      RUN: begin
        if (stage_end) begin
          k_n    = '0;
          i_n    = '0;
          cnt_n  = '0;
          rev_n  = 1'b0;
          last_n = 1'b0;
          if (pass_end) begin
            p_n    = '0;
            vld_n  = 1'b0;
            busy_n = 1'b0;
            done_n = 1'b1;
          end else begin
            p_n         = ntt_flag ? p + PW'(1) : p - PW'(1);
            stage_idx_n = stage_idx + PW'(1);
            gap_cnt_n   = '0;
            vld_n       = (STAGE_GAP == 0);
          end
        end else if (accept) begin
          cnt_n  = cnt_addr_gen + CW'(1);
          last_n = (cnt_addr_gen == CNT_LAST - CW'(1));
          if (p >= PW'(2)) begin
            if (i == i_max) begin
              i_n = '0;
              k_n = k + KW'(1);
            end else begin
              i_n = i + KW'(1);
            end
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt + GW'(1);
        if (gap_end) vld_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      i            <= '0;
      p            <= '0;
      cnt_addr_gen <= '0;
      ntt_flag     <= 1'b0;
      rev          <= 1'b0;
      addr_vld     <= 1'b0;
      stage_last   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stage_idx    <= '0;
      gap_cnt      <= '0;
    end else begin
      k            <= k_n;
      i            <= i_n;
      p            <= p_n;
      cnt_addr_gen <= cnt_n;
      ntt_flag     <= flag_n;
      rev          <= rev_n;
      addr_vld     <= vld_n;
      stage_last   <= last_n;
      busy         <= busy_n;
      done         <= done_n;
      stage_idx    <= stage_idx_n;
      gap_cnt      <= gap_cnt_n;
    end
  end

endmodule

// File: tb/tb_ntt_addr_seq.sv
// tb/tb_ntt_addr_seq.sv - directed self-checking bench for ntt_addr_seq
module tb_ntt_addr_seq;

  logic clk = 1'b0;
  logic rst, start, start0, intt_mode, bitrev_en, stall;

  logic [8:0] k, i, k0, i0;
  logic [3:0] p, p0;
  logic [6:0] cnt, cnt0;
  logic ntt_flag, rev, vld, slast, busy, done;
  logic ntt_flag0, rev0, vld0, slast0, busy0, done0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ntt_addr_seq #(.N_LOG2(10), .BFU_NUM(4), .STAGE_GAP(6)) dut (
    .clk(clk), .rst(rst), .start(start), .intt_mode(intt_mode), .bitrev_en(bitrev_en),
    .stall(stall), .k(k), .i(i), .p(p), .cnt_addr_gen(cnt), .ntt_flag(ntt_flag),
    .rev(rev), .addr_vld(vld), .stage_last(slast), .busy(busy), .done(done));

  ntt_addr_seq #(.N_LOG2(10), .BFU_NUM(4), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .intt_mode(intt_mode), .bitrev_en(bitrev_en),
    .stall(stall), .k(k0), .i(i0), .p(p0), .cnt_addr_gen(cnt0), .ntt_flag(ntt_flag0),
    .rev(rev0), .addr_vld(vld0), .stage_last(slast0), .busy(busy0), .done(done0));

  // Called at a negedge in IDLE; returns at the negedge of cycle 1 (first tuple).
  task automatic begin_pass(input logic mode, input logic br, input logic use_gap0);
    intt_mode = mode;
    bitrev_en = br;
    if (use_gap0) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; start0 = 1'b1; intt_mode = 1'b1; bitrev_en = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done});
    end
    n_checks++;
    if ({k0, i0, p0, cnt0, ntt_flag0, rev0, vld0, slast0, busy0, done0} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_gap0 got=%h exp=0", {k0, i0, p0, cnt0, ntt_flag0, rev0, vld0, slast0, busy0, done0});
    end
    rst = 1'b0; start = 1'b0; start0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ntt;
    int done_cyc = 0;
    int vld_cnt  = 0;
    begin_pass(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 1500; c++) begin
      if (vld) vld_cnt++;
      if (c == 1) begin
        n_checks++;
        if ({p, k, i, cnt, vld, busy, ntt_flag, rev} !== {4'd9, 9'd0, 9'd0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL ntt_first_tuple got p=%0d k=%0d i=%0d cnt=%0d vld=%b busy=%b exp p=9 k=0 i=0 cnt=0 vld=1 busy=1", p, k, i, cnt, vld, busy);
        end
      end
      if (c == 2) begin
        n_checks++;
        if ({k, i, cnt} !== {9'd0, 9'd1, 7'd1}) begin
          n_fail++;
          $display("FAIL ntt_second_tuple got k=%0d i=%0d cnt=%0d exp k=0 i=1 cnt=1", k, i, cnt);
        end
      end
      if (c == 128) begin
        n_checks++;
        if ({cnt, slast, vld} !== {7'd127, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL ntt_stage_last got cnt=%0d last=%b vld=%b exp cnt=127 last=1 vld=1", cnt, slast, vld);
        end
      end
      if (c == 129 || c == 134) begin
        n_checks++;
        if ({vld, slast} !== 2'b00) begin
          n_fail++;
          $display("FAIL ntt_gap_cycle%0d got vld=%b last=%b exp 0 0", c, vld, slast);
        end
      end
      if (c == 135) begin
        n_checks++;
        if ({p, k, i, cnt, vld} !== {4'd8, 9'd0, 9'd0, 7'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL ntt_second_stage got p=%0d k=%0d cnt=%0d vld=%b exp p=8 k=0 cnt=0 vld=1", p, k, cnt, vld);
        end
      end
      if (c == 1334) begin
        n_checks++;
        if ({p, k, i, cnt, vld, slast} !== {4'd0, 9'd127, 9'd0, 7'd127, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL ntt_last_tuple got p=%0d k=%0d i=%0d cnt=%0d exp p=0 k=127 i=0 cnt=127", p, k, i, cnt);
        end
      end
      if (done) begin
        done_cyc = c;
        n_checks++;
        if ({busy, vld} !== 2'b00) begin
          n_fail++;
          $display("FAIL ntt_done_state got busy=%b vld=%b exp 0 0", busy, vld);
        end
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_cyc != 1335) begin
      n_fail++;
      $display("FAIL ntt_done_cycle got=%0d exp=1335", done_cyc);
    end
    n_checks++;
    if (vld_cnt != 1280) begin
      n_fail++;
      $display("FAIL ntt_tuple_count got=%0d exp=1280", vld_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_intt;
    int done_cyc = 0;
    int p0_bad   = 0;
    int last_p   = -1;
    logic [3:0] first_p;
    logic       first_flag;
    begin_pass(1'b1, 1'b0, 1'b0);
    first_p    = p;
    first_flag = ntt_flag;
    for (int c = 1; c <= 1500; c++) begin
      if (vld) begin
        last_p = int'(p);
        if (p == 4'd0 && ({2'b0, k} !== {4'b0, cnt} || i !== 9'd0)) p0_bad++;
        if (p == 4'd3 && cnt == 7'd5) begin
          n_checks++;
          if ({k, i} !== {9'd2, 9'd1}) begin
            n_fail++;
            $display("FAIL intt_p3_cnt5 got k=%0d i=%0d exp k=2 i=1", k, i);
          end
        end
        if (p == 4'd9 && cnt == 7'd127) begin
          n_checks++;
          if ({k, i} !== {9'd0, 9'd127}) begin
            n_fail++;
            $display("FAIL intt_p9_cnt127 got k=%0d i=%0d exp k=0 i=127", k, i);
          end
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({first_p, first_flag} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL intt_first_stage got p=%0d flag=%b exp p=0 flag=1", first_p, first_flag);
    end
    n_checks++;
    if (p0_bad != 0) begin
      n_fail++;
      $display("FAIL intt_p0_k_eq_cnt got bad=%0d exp=0", p0_bad);
    end
    n_checks++;
    if (last_p != 9 || done_cyc != 1335) begin
      n_fail++;
      $display("FAIL intt_final got last_p=%0d done_cyc=%0d exp 9 1335", last_p, done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    int done_cyc = 0;
    logic [34:0] snap;
    begin_pass(1'b0, 1'b0, 1'b0);
    snap = '0;
    for (int c = 1; c <= 1500; c++) begin
      if (c == 41) begin
        snap = {k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done};
        n_checks++;
        if ({cnt, vld} !== {7'd40, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_setup got cnt=%0d vld=%b exp 40 1", cnt, vld);
        end
        stall = 1'b1;
      end
      if (c >= 42 && c <= 44) begin
        n_checks++;
        if ({k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done} !== snap) begin
          n_fail++;
          $display("FAIL stall_hold_c%0d got cnt=%0d vld=%b exp cnt=40 vld=1", c, cnt, vld);
        end
        if (c == 44) stall = 1'b0;
      end
      if (c == 45) begin
        n_checks++;
        if (cnt !== 7'd41) begin
          n_fail++;
          $display("FAIL stall_resume got cnt=%0d exp 41", cnt);
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    stall = 1'b0;
    n_checks++;
    if (done_cyc != 1338) begin
      n_fail++;
      $display("FAIL stall_done_cycle got=%0d exp=1338", done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_bitrev;
    int rev_first = 0;
    int rev_later = 0;
    int done_cyc  = 0;
    begin_pass(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 1500; c++) begin
      if (vld && rev) begin
        if (p == 4'd9) rev_first++;
        else           rev_later++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (rev_first != 128 || rev_later != 0 || done_cyc != 1335) begin
      n_fail++;
      $display("FAIL bitrev_counts got first=%0d later=%0d done=%0d exp 128 0 1335", rev_first, rev_later, done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_gap0;
    int done_cyc = 0;
    int vld_low  = 0;
    begin_pass(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 1500; c++) begin
      if (c <= 1280 && !vld0) vld_low++;
      if (c == 128) begin
        n_checks++;
        if ({p0, cnt0, slast0} !== {4'd9, 7'd127, 1'b1}) begin
          n_fail++;
          $display("FAIL gap0_end_stage got p=%0d cnt=%0d last=%b exp 9 127 1", p0, cnt0, slast0);
        end
      end
      if (c == 129) begin
        n_checks++;
        if ({p0, cnt0, k0, vld0, slast0} !== {4'd8, 7'd0, 9'd0, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL gap0_next_stage got p=%0d cnt=%0d vld=%b exp 8 0 1", p0, cnt0, vld0);
        end
      end
      if (done0) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (vld_low != 0 || done_cyc != 1281) begin
      n_fail++;
      $display("FAIL gap0_pass got vld_low=%0d done=%0d exp 0 1281", vld_low, done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_control;
    int hit      = 0;
    int spurious = 0;
    int done_cyc = 0;
    begin_pass(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 1500; c++) begin
      if (c == 10) begin
        intt_mode = 1'b1;
        start     = 1'b1;
      end
      if (c == 11) begin
        start = 1'b0;
        n_checks++;
        if ({p, cnt, ntt_flag, busy} !== {4'd9, 7'd10, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL ctrl_start_ignored got p=%0d cnt=%0d flag=%b busy=%b exp 9 10 0 1", p, cnt, ntt_flag, busy);
        end
      end
      if (vld && p == 4'd5 && cnt == 7'd3) begin
        hit = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done} !== 35'd0) begin
          n_fail++;
          $display("FAIL ctrl_midpass_reset got=%h exp=0", {k, i, p, cnt, ntt_flag, rev, vld, slast, busy, done});
        end
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (hit != 1) begin
      n_fail++;
      $display("FAIL ctrl_reach_p5 got=%0d exp=1", hit);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL ctrl_no_done_after_reset got=%0d exp=0", spurious);
    end
    begin_pass(1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({p, cnt, vld, busy} !== {4'd0, 7'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ctrl_clean_start got p=%0d cnt=%0d vld=%b exp 0 0 1", p, cnt, vld);
    end
    for (int c = 1; c <= 1500; c++) begin
      if (done) begin
        done_cyc = c;
        start    = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, vld, done} !== 3'b000 || done_cyc != 1335) begin
      n_fail++;
      $display("FAIL ctrl_done_start_ignored got busy=%b vld=%b done=%b done_cyc=%0d exp 0 0 0 1335", busy, vld, done, done_cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; intt_mode = 1'b0; bitrev_en = 1'b0; stall = 1'b0;
    @(negedge clk);
    test_reset();
    test_ntt();
    test_intt();
    test_stall();
    test_bitrev();
    test_gap0();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
